// File: rtl/tv_pkg.sv
// ---------------------------------------------------------------------------
// tv_pkg
//   Shared definitions for the tv_checker self-test vector engine.
//   - state_t          : engine FSM states
//   - field_slice      : generic field extractor for a packed vector
//   - vec_stim/exp/mask: pull the stimulus, expected and mask fields out of a
//                        packed {stim, exp, mask} table word (MSB first)
//   The helpers work on a 64-bit carrier, so a packed vector may be at most
//   64 bits wide. Callers cast the result down to the field width.
// ---------------------------------------------------------------------------
package tv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAX_VEC_W = 64;

    // Returns 'width' bits of 'vec' starting at bit 'lsb', zero-extended.
    function automatic logic [MAX_VEC_W-1:0] field_slice(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   lsb,
        input int                   width
    );
        logic [MAX_VEC_W-1:0] field_mask;
        if (width >= MAX_VEC_W) begin
            field_mask = '1;
        end else begin
            field_mask = (64'd1 << width) - 64'd1;
        end
        return (vec >> lsb) & field_mask;
    endfunction

    // Stimulus occupies the top in_w bits, above exp and mask.
    function automatic logic [MAX_VEC_W-1:0] vec_stim(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   in_w,
        input int                   out_w
    );
        return field_slice(vec, 2 * out_w, in_w);
    endfunction

    function automatic logic [MAX_VEC_W-1:0] vec_exp(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   out_w
    );
        return field_slice(vec, out_w, out_w);
    endfunction

    function automatic logic [MAX_VEC_W-1:0] vec_mask(
        input logic [MAX_VEC_W-1:0] vec,
        input int                   out_w
    );
        return field_slice(vec, 0, out_w);
    endfunction

endpackage

// File: rtl/tv_checker_delay.sv
// ---------------------------------------------------------------------------
// tv_delay_line
//   LAT+1 stage shift register carrying the compare tag {valid, idx, exp,
//   mask} of each issued vector alongside the DUT pipeline. Stage 0 is loaded
//   on the issue edge; the last stage is the compare stage.
//   Ports:
//     clk, reset          : clock, synchronous active-low clear
//     in_valid/idx/exp/mask   : tag entering stage 0
//     out_valid/idx/exp/mask  : tag in the last (compare) stage
//     pending             : a valid tag sits in a stage before the last one,
//                           i.e. the line will not be empty after this edge
// ---------------------------------------------------------------------------
module tv_delay_line #(
    parameter int LAT   = 0,
    parameter int IDX_W = 4,
    parameter int OUT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [OUT_W-1:0] in_exp,
    input  logic [OUT_W-1:0] in_mask,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [OUT_W-1:0] out_exp,
    output logic [OUT_W-1:0] out_mask,
    output logic             pending
);

    logic [LAT:0]            valid_q, valid_d;
    logic [LAT:0][IDX_W-1:0] idx_q, idx_d;
    logic [LAT:0][OUT_W-1:0] exp_q, exp_d;
    logic [LAT:0][OUT_W-1:0] mask_q, mask_d;

    // Shift every stage one place towards the compare end.
    always_comb begin
        valid_d    = '0;
        idx_d      = '0;
        exp_d      = '0;
        mask_d     = '0;
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        exp_d[0]   = in_exp;
        mask_d[0]  = in_mask;
        for (int i = 1; i <= LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
            exp_d[i]   = exp_q[i-1];
            mask_d[i]  = mask_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            idx_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
        end
    end

    assign out_valid = valid_q[LAT];
    assign out_idx   = idx_q[LAT];
    assign out_exp   = exp_q[LAT];
    assign out_mask  = mask_q[LAT];

    // With no extra stages the only tag is always in the compare stage.
    generate
        if (LAT == 0) begin : g_no_pending
            assign pending = 1'b0;
        end else begin : g_pending
            assign pending = |valid_q[LAT-1:0];
        end
    endgenerate

endmodule

// File: rtl/tv_checker.sv
// ---------------------------------------------------------------------------
// tv_checker
//   On-chip self-test vector engine. A loadable table of {stim, exp, mask}
//   vectors is played into a DUT one per clock; each response is compared
//   LAT clocks later against exp under mask, and the run reports an error
//   count, the first failing index and pass/fail.
//   Ports:
//     clk, reset       : clock, synchronous active-low reset
//     ld_en/addr/data  : table write port (ignored while busy)
//     start, num_vec   : launch a run of num_vec vectors (clamped to DEPTH)
//     dut_in, dut_out  : registered stimulus to / response from the DUT
//     busy, done, pass : run status; pass is meaningful while done is high
//     err_cnt          : mismatching vectors in this run
//     first_err_valid/idx : index of the first mismatching vector
// ---------------------------------------------------------------------------
module tv_checker
    import tv_pkg::*;
#(
    parameter  int IN_W   = 3,
    parameter  int OUT_W  = 1,
    parameter  int DEPTH  = 16,
    parameter  int LAT    = 0,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int VEC_W  = IN_W + 2 * OUT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [VEC_W-1:0]  ld_data,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vec,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_idx
);

    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [VEC_W-1:0] table_mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] issue_idx_q, issue_idx_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic              first_err_valid_q, first_err_valid_d;
    logic [ADDR_W-1:0] first_err_idx_q, first_err_idx_d;

    logic [VEC_W-1:0]  rd_vec;
    logic [63:0]       rd_vec_wide;
    logic [IN_W-1:0]   rd_stim;
    logic [OUT_W-1:0]  rd_exp;
    logic [OUT_W-1:0]  rd_mask;
    logic [ADDR_W:0]   n_clamped;
    logic              last_issue;
    logic              issue_valid;
    logic              tag_valid;
    logic [ADDR_W-1:0] tag_idx;
    logic [OUT_W-1:0]  tag_exp;
    logic [OUT_W-1:0]  tag_mask;
    logic              pending;
    logic              mismatch;

    // Table writes are locked out for the whole run so the vectors being
    // issued cannot change underneath the engine.
    always_ff @(posedge clk) begin
        if (ld_en && !busy_q && ({1'b0, ld_addr} < DEPTH_C)) begin
            table_mem[ld_addr] <= ld_data;
        end
    end

    assign rd_vec      = table_mem[issue_idx_q];
    assign rd_vec_wide = 64'(rd_vec);
    assign rd_stim     = IN_W'(vec_stim(rd_vec_wide, IN_W, OUT_W));
    assign rd_exp      = OUT_W'(vec_exp(rd_vec_wide, OUT_W));
    assign rd_mask     = OUT_W'(vec_mask(rd_vec_wide, OUT_W));

    assign n_clamped  = (num_vec > DEPTH_C) ? DEPTH_C : num_vec;
    assign last_issue = ({1'b0, issue_idx_q} == (n_q - 1'b1));

    tv_delay_line #(
        .LAT   (LAT),
        .IDX_W (ADDR_W),
        .OUT_W (OUT_W)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue_valid),
        .in_idx    (issue_idx_q),
        .in_exp    (rd_exp),
        .in_mask   (rd_mask),
        .out_valid (tag_valid),
        .out_idx   (tag_idx),
        .out_exp   (tag_exp),
        .out_mask  (tag_mask),
        .pending   (pending)
    );

    // Masked-off bits never count, so an X/Z response on a don't-care bit
    // cannot produce a mismatch.
    assign mismatch = |((dut_out ^ tag_exp) & tag_mask);

    // Next-state logic: compare bookkeeping first, then the FSM, so that a
    // start in IDLE/DONE overrides any result bookkeeping of the same cycle.
    always_comb begin
        state_d           = state_q;
        n_d               = n_q;
        issue_idx_d       = issue_idx_q;
        dut_in_d          = dut_in_q;
        pass_d            = pass_q;
        err_cnt_d         = err_cnt_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        issue_valid       = 1'b0;

        if (tag_valid && mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (!first_err_valid_q) begin
                first_err_valid_d = 1'b1;
                first_err_idx_d   = tag_idx;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_cnt_d         = '0;
                    first_err_valid_d = 1'b0;
                    first_err_idx_d   = '0;
                    pass_d            = 1'b0;
                    issue_idx_d       = '0;
                    n_d               = n_clamped;
                    if (n_clamped == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                issue_valid = 1'b1;
                dut_in_d    = rd_stim;
                if (last_issue) begin
                    state_d = DRAIN;
                end else begin
                    issue_idx_d = issue_idx_q + 1'b1;
                end
            end
            DRAIN: begin
                // Leaving on the edge of the final compare, so pass must see
                // the count including that compare.
                if (!pending) begin
                    state_d = DONE;
                    pass_d  = (err_cnt_d == '0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // All engine state and outputs are registered here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q           <= IDLE;
            n_q               <= '0;
            issue_idx_q       <= '0;
            dut_in_q          <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
        end else begin
            state_q           <= state_d;
            n_q               <= n_d;
            issue_idx_q       <= issue_idx_d;
            dut_in_q          <= dut_in_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            err_cnt_q         <= err_cnt_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
        end
    end

    assign dut_in          = dut_in_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;

endmodule

// File: tb/tb_tv_checker.sv
// ---------------------------------------------------------------------------
// tb_tv_checker
//   Two tv_checker instances share the table/start inputs: one with LAT=0
//   driving a combinational y = ~b&~c | a&~b, one with LAT=2 driving the
//   same function either through two register stages or unregistered.
//   Results are compared against a vector-level model of each run.
// ---------------------------------------------------------------------------
module tb_tv_checker;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 1;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int VEC_W  = IN_W + 2 * OUT_W;
    localparam int BUDGET = 40;

    logic clk;
    logic reset;
    logic ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [VEC_W-1:0]  ld_data;
    logic start;
    logic [ADDR_W:0]   num_vec;

    logic [IN_W-1:0]   dut_in_a, dut_in_b;
    logic [OUT_W-1:0]  dut_out_a, dut_out_b;
    logic              busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [ADDR_W:0]   err_a, err_b;
    logic              fev_a, fev_b;
    logic [ADDR_W-1:0] fei_a, fei_b;

    logic              lat2_comb;
    logic [OUT_W-1:0]  lat2_r1, lat2_r2;

    logic [IN_W-1:0]   tb_stim [DEPTH];
    logic              tb_exp  [DEPTH];
    logic              tb_mask [DEPTH];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table of y = ~b&~c | a&~b indexed by {a,b,c}: ones at 000,100,101.
    function automatic logic refY(input logic [IN_W-1:0] abc);
        logic [7:0] truth;
        truth = 8'b0011_0001;
        return truth[abc];
    endfunction

    assign dut_out_a = refY(dut_in_a);

    always @(posedge clk) begin
        lat2_r1 <= refY(dut_in_b);
        lat2_r2 <= lat2_r1;
    end

    assign dut_out_b = lat2_comb ? refY(dut_in_b) : lat2_r2;

    tv_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(0)) u_dut_lat0 (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .num_vec(num_vec), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .first_err_valid(fev_a), .first_err_idx(fei_a)
    );

    tv_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .LAT(2)) u_dut_lat2 (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .num_vec(num_vec), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .first_err_valid(fev_b), .first_err_idx(fei_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic loadVector(input int addr, input logic [IN_W-1:0] s,
                              input logic e, input logic m);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = addr[ADDR_W-1:0];
        ld_data = {s, e, m};
        tb_stim[addr] = s;
        tb_exp[addr]  = e;
        tb_mask[addr] = m;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic checkResetValues(input string who);
        checkOutput({who, "_dut_in_lat0"}, 32'(dut_in_a), 0);
        checkOutput({who, "_busy_lat0"},   32'(busy_a),   0);
        checkOutput({who, "_done_lat0"},   32'(done_a),   0);
        checkOutput({who, "_pass_lat0"},   32'(pass_a),   0);
        checkOutput({who, "_err_lat0"},    32'(err_a),    0);
        checkOutput({who, "_fev_lat0"},    32'(fev_a),    0);
        checkOutput({who, "_fei_lat0"},    32'(fei_a),    0);
        checkOutput({who, "_dut_in_lat2"}, 32'(dut_in_b), 0);
        checkOutput({who, "_busy_lat2"},   32'(busy_b),   0);
        checkOutput({who, "_done_lat2"},   32'(done_b),   0);
        checkOutput({who, "_pass_lat2"},   32'(pass_b),   0);
        checkOutput({who, "_err_lat2"},    32'(err_b),    0);
        checkOutput({who, "_fev_lat2"},    32'(fev_b),    0);
        checkOutput({who, "_fei_lat2"},    32'(fei_b),    0);
    endtask

    // Vector-level model. With an unregistered DUT behind a LAT-deep compare,
    // vector i is judged on the stimulus present LAT vectors later (the last
    // stimulus is held once the run stops issuing).
    task automatic modelRun(input int n, input int lat, input bit comb_view,
                            output int e_err, output int e_fev, output int e_fei,
                            output int e_pass, output int e_edge);
        int neff;
        int src;
        neff   = (n > DEPTH) ? DEPTH : n;
        e_err  = 0;
        e_fev  = 0;
        e_fei  = 0;
        for (int i = 0; i < neff; i++) begin
            src = i;
            if (comb_view && lat > 0) src = (i + lat < neff) ? i + lat : neff - 1;
            if (tb_mask[i] && (refY(tb_stim[src]) != tb_exp[i])) begin
                if (e_fev == 0) begin
                    e_fev = 1;
                    e_fei = i;
                end
                e_err++;
            end
        end
        e_pass = (e_err == 0) ? 1 : 0;
        e_edge = (neff == 0) ? 0 : neff + 1 + lat;
    endtask

    // Start a run of n vectors, record the edge (edge 0 samples start) after
    // which each instance shows done, then check results against the model.
    task automatic applyStimulus(input int n, input bit interfere, input string name);
        int edge_a, edge_b, neff;
        int e_err, e_fev, e_fei, e_pass, e_edge;
        edge_a = -1;
        edge_b = -1;
        neff   = (n > DEPTH) ? DEPTH : n;
        @(negedge clk);
        start   = 1'b1;
        num_vec = n[ADDR_W:0];
        @(posedge clk);
        for (int e = 0; e < BUDGET; e++) begin
            @(negedge clk);
            if (e == 0) begin
                start = 1'b0;
                checkOutput({name, "_busy_lat0"}, 32'(busy_a), (neff > 0) ? 1 : 0);
            end
            if (interfere && e == 2) begin
                ld_en   = 1'b1;
                ld_addr = 4'd5;
                ld_data = {tb_stim[5], ~tb_exp[5], 1'b1};
                start   = 1'b1;
                num_vec = 5'd3;
            end
            if (interfere && e == 3) begin
                ld_en = 1'b0;
                start = 1'b0;
            end
            if (done_a && edge_a < 0) edge_a = e;
            if (done_b && edge_b < 0) edge_b = e;
            if (edge_a >= 0 && edge_b >= 0) break;
            @(posedge clk);
        end

        modelRun(n, 0, 1'b0, e_err, e_fev, e_fei, e_pass, e_edge);
        checkOutput({name, "_done_edge_lat0"}, 32'(edge_a), 32'(e_edge));
        checkOutput({name, "_err_lat0"},  32'(err_a),  32'(e_err));
        checkOutput({name, "_fev_lat0"},  32'(fev_a),  32'(e_fev));
        checkOutput({name, "_fei_lat0"},  32'(fei_a),  32'(e_fei));
        checkOutput({name, "_pass_lat0"}, 32'(pass_a), 32'(e_pass));

        modelRun(n, 2, lat2_comb, e_err, e_fev, e_fei, e_pass, e_edge);
        checkOutput({name, "_done_edge_lat2"}, 32'(edge_b), 32'(e_edge));
        checkOutput({name, "_err_lat2"},  32'(err_b),  32'(e_err));
        checkOutput({name, "_fev_lat2"},  32'(fev_b),  32'(e_fev));
        checkOutput({name, "_fei_lat2"},  32'(fei_b),  32'(e_fei));
        checkOutput({name, "_pass_lat2"}, 32'(pass_b), 32'(e_pass));
    endtask

    initial begin
        logic [IN_W-1:0] s;
        reset     = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        start     = 1'b0;
        num_vec   = '0;
        lat2_comb = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;

        // Full truth table, correct DUT.
        for (int i = 0; i < 8; i++) loadVector(i, 3'(i), refY(3'(i)), 1'b1);
        applyStimulus(8, 1'b0, "good");

        // Vector 5 expectation wrong, then vector 2 as well.
        loadVector(5, 3'd5, ~refY(3'd5), 1'b1);
        applyStimulus(8, 1'b0, "bad5");
        checkOutput("bad5_err_direct", 32'(err_a), 1);
        checkOutput("bad5_fei_direct", 32'(fei_a), 5);
        loadVector(2, 3'd2, ~refY(3'd2), 1'b1);
        applyStimulus(8, 1'b0, "bad2and5");
        checkOutput("bad2and5_err_direct", 32'(err_a), 2);
        checkOutput("bad2and5_fei_direct", 32'(fei_a), 2);

        // Wrong expectation hidden by a zero mask.
        loadVector(2, 3'd2, refY(3'd2), 1'b1);
        loadVector(5, 3'd5, ~refY(3'd5), 1'b0);
        applyStimulus(8, 1'b0, "masked5");
        checkOutput("masked5_pass_direct", 32'(pass_a), 1);

        // Unregistered DUT behind the LAT=2 checker must be caught.
        loadVector(5, 3'd5, refY(3'd5), 1'b1);
        lat2_comb = 1'b1;
        applyStimulus(8, 1'b0, "lat2_comb");
        checkOutput("lat2_comb_has_err", 32'(err_b != 0), 1);
        lat2_comb = 1'b0;

        // Empty run and clamped oversize run.
        applyStimulus(0, 1'b0, "n0");
        for (int i = 8; i < DEPTH; i++) begin
            s = 3'($urandom_range(0, 7));
            loadVector(i, s, refY(s), 1'b1);
        end
        applyStimulus(20, 1'b0, "clamp20");

        // Reset while issue_idx is 3 (vectors 0..2 issued on edges 1..3).
        @(negedge clk);
        start   = 1'b1;
        num_vec = 5'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("midrun_busy", 32'(busy_a), 1);
        checkOutput("midrun_dut_in", 32'(dut_in_a), 32'(tb_stim[2]));
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midrun_reset");
        reset = 1'b1;
        applyStimulus(8, 1'b0, "after_reset");

        // Table write and start during the run are ignored; rerun proves the
        // table was not corrupted.
        applyStimulus(8, 1'b1, "interfere");
        applyStimulus(8, 1'b0, "interfere_rerun");

        // Random tables, lengths and DUT wrapping.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                s = 3'($urandom_range(0, 7));
                loadVector(i, s, refY(s) ^ ($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 1)));
            end
            lat2_comb = 1'($urandom_range(0, 1));
            applyStimulus(int'($urandom_range(0, 20)), 1'b0, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
